// File: rtl/heaa_err_monitor.sv
// Streaming error monitor for the 12-bit HEAA approximate adder: per-window ED sum, max and count.
// Optional ED^2 accumulation is built when HEAA_MON_MSE_EN is defined.
module heaa_err_monitor #(
  parameter int WINDOW = 256,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      a,
  input  logic [11:0]      b,
  input  logic [12:0]      approx_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] err_sum,
  output logic [12:0]      err_max,
  output logic [15:0]      err_cnt,
  output logic             busy,
`ifdef HEAA_MON_MSE_EN
  output logic [47:0]      err_sq_sum,
`endif
  output logic [1:0]       dbg_state
);

  // Handshakes: a sample transfers on a rising edge where in_valid & in_ready are both high;
  // a result transfers on a rising edge where out_valid & out_ready are both high.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam logic [15:0] WIN16 = 16'(WINDOW);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic        accept;
  logic        clear;
  logic        s1_valid_q;
  logic [12:0] ed_q;
  logic [12:0] exact;
  logic [12:0] ed_d;
  logic [ACC_W:0] sum_ext;

  assign in_ready  = (state_q == S_ACCUM) && (cnt_q < WIN16);
  assign accept    = in_valid & in_ready;
  assign clear     = (state_q == S_IDLE) && start;
  assign out_valid = (state_q == S_REPORT);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCUM;
      S_ACCUM:  if (accept && (cnt_q == WIN16 - 16'd1)) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_REPORT;
      S_REPORT: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + 16'd1;
  end

  // Stage 1: exact sum and absolute error distance
  assign exact = {1'b0, a} + {1'b0, b};
  assign ed_d  = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      ed_q       <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) ed_q <= ed_d;
    end
  end

  // Stage 2: saturating accumulation
  assign sum_ext = {1'b0, err_sum} + (ACC_W+1)'(ed_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum <= '0;
      err_max <= '0;
      err_cnt <= '0;
    end else if (clear) begin
      err_sum <= '0;
      err_max <= '0;
      err_cnt <= '0;
    end else if (s1_valid_q) begin
      err_sum <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      if (ed_q > err_max) err_max <= ed_q;
      if ((ed_q != 13'd0) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

`ifdef HEAA_MON_MSE_EN
  // Squaring is combinational in stage 2, so DRAIN stays a single cycle.
  logic [25:0] ed_sq;
  logic [48:0] sq_ext;
  assign ed_sq  = {13'd0, ed_q} * {13'd0, ed_q};
  assign sq_ext = {1'b0, err_sq_sum} + {23'd0, ed_sq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_sq_sum <= '0;
    else if (clear)      err_sq_sum <= '0;
    else if (s1_valid_q) err_sq_sum <= sq_ext[48] ? {48{1'b1}} : sq_ext[47:0];
  end
`endif

endmodule

// File: tb/tb_heaa_err_monitor.sv
// Self-checking bench for heaa_err_monitor (WINDOW=4, ACC_W=13): table windows,
// hand-written corner sequences and random gapped windows against a window-level model.
module tb_heaa_err_monitor;

  localparam int WINDOW = 4;
  localparam int ACC_W  = 13;
  localparam int RW     = ACC_W + 13 + 16;
  localparam longint SAT = (64'd1 << ACC_W) - 1;

  logic             clk, rst_n, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [11:0]      a, b;
  logic [12:0]      approx_sum;
  logic [ACC_W-1:0] err_sum;
  logic [12:0]      err_max;
  logic [15:0]      err_cnt;
  logic [1:0]       dbg_state;
`ifdef HEAA_MON_MSE_EN
  logic [47:0]      err_sq_sum;
`endif

  heaa_err_monitor #(.WINDOW(WINDOW), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_sum(approx_sum), .out_valid(out_valid), .out_ready(out_ready),
    .err_sum(err_sum), .err_max(err_max), .err_cnt(err_cnt), .busy(busy),
`ifdef HEAA_MON_MSE_EN
    .err_sq_sum(err_sq_sum),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [11:0] a[4];
    logic [11:0] b[4];
    logic [12:0] apx[4];
    logic [12:0] e_sum;
    logic [12:0] e_max;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[4];

  function automatic logic [RW-1:0] results();
    return {err_sum, err_max, err_cnt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference model: plain arithmetic over the window's sample list
  function automatic int ed_of(input logic [11:0] x, input logic [11:0] y, input logic [12:0] apx);
    int ex;
    int ap;
    ex = int'(x) + int'(y);
    ap = int'(apx);
    return (ex > ap) ? ex - ap : ap - ex;
  endfunction

  function automatic logic [RW-1:0] model(input int eds[$]);
    longint s = 0;
    int mx = 0;
    int c = 0;
    foreach (eds[i]) begin
      s += eds[i];
      if (eds[i] > mx) mx = eds[i];
      if (eds[i] != 0) c++;
    end
    if (s > SAT) s = SAT;
    return {ACC_W'(s), 13'(mx), 16'(c)};
  endfunction

  // Lower 9 bits OR-ed, carry into the accurate part from bit 8 generate
  function automatic logic [12:0] approx_heaa(input logic [11:0] x, input logic [11:0] y);
    logic [3:0] up;
    up = {1'b0, x[11:9]} + {1'b0, y[11:9]} + {3'd0, x[8] & y[8]};
    return {up, x[8:0] | y[8:0]};
  endfunction

  // Driver tasks (entered and left on a falling edge)
  task automatic start_window();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("in_ready_after_start", 64'(in_ready), 64'd1);
    check("clear_on_entry", 64'(results()), 64'd0);
  endtask

  task automatic send(input logic [11:0] x, input logic [11:0] y, input logic [12:0] apx);
    int guard;
    guard = 0;
    a = x; b = y; approx_sum = apx; in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_drain();
    check("drain_state", 64'({out_valid, busy, in_ready}), 64'b010);
    @(negedge clk);
    check("out_valid_latency", 64'(out_valid), 64'd1);
  endtask

  task automatic get_result();
    int guard;
    logic [RW-1:0] e;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("out_valid_timeout", 64'd0, 64'd1);
    e = exp_q.pop_front();
    check("window_results", 64'(results()), 64'(e));
  endtask

  task automatic handshake(input logic with_start);
    logic [RW-1:0] held;
    held = results();
    out_ready = 1'b1;
    start = with_start;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("valid_busy_drop", 64'({out_valid, busy}), 64'd0);
    check("hold_after_handshake", 64'(results()), 64'(held));
    if (with_start) begin
      @(negedge clk);
      check("start_in_report_ignored", 64'({busy, in_ready}), 64'd0);
    end
  endtask

  initial begin
    int eds[$];
    int bad;
    logic [11:0] x, y;
    logic [12:0] apx;
    logic [RW-1:0] held;

    tbl[0].a = '{12'h0FF, 12'h0FF, 12'h100, 12'h000};
    tbl[0].b = '{12'h001, 12'h0FF, 12'h100, 12'h000};
    tbl[0].apx = '{13'h0FF, 13'h0FF, 13'h200, 13'h000};
    tbl[0].e_sum = 13'd256; tbl[0].e_max = 13'd255; tbl[0].e_cnt = 16'd2;
    tbl[1].a = '{12'h000, 12'h000, 12'h000, 12'h000};
    tbl[1].b = '{12'h000, 12'h000, 12'h000, 12'h000};
    tbl[1].apx = '{13'hFFF, 13'hFFF, 13'hFFF, 13'hFFF};
    tbl[1].e_sum = 13'd8191; tbl[1].e_max = 13'd4095; tbl[1].e_cnt = 16'd4;
    tbl[2].a = '{12'h123, 12'hFFF, 12'h800, 12'h001};
    tbl[2].b = '{12'h456, 12'hFFF, 12'h800, 12'h000};
    tbl[2].apx = '{13'h0579, 13'h1FFE, 13'h1000, 13'h0001};
    tbl[2].e_sum = 13'd0; tbl[2].e_max = 13'd0; tbl[2].e_cnt = 16'd0;
    tbl[3].a = '{12'hFFF, 12'h000, 12'h000, 12'h001};
    tbl[3].b = '{12'hFFF, 12'h000, 12'h000, 12'h000};
    tbl[3].apx = '{13'h0000, 13'h1FFF, 13'h0000, 13'h0000};
    tbl[3].e_sum = 13'd8191; tbl[3].e_max = 13'd8191; tbl[3].e_cnt = 16'd3;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; approx_sum = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({in_ready, out_valid, busy, results()}), 64'd0);
    rst_n = 1'b1;

    // Sample offered in IDLE without start must never be taken
    a = 12'h010; b = 12'h020; approx_sum = 13'h000; in_valid = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (in_ready || busy || out_valid || results() != '0) bad++;
    end
    in_valid = 1'b0;
    check("idle_no_accept", 64'(bad), 64'd0);

    // Table-driven windows
    for (int i = 0; i < 4; i++) begin
      start_window();
      for (int j = 0; j < WINDOW; j++) send(tbl[i].a[j], tbl[i].b[j], tbl[i].apx[j]);
      exp_q.push_back({tbl[i].e_sum, tbl[i].e_max, tbl[i].e_cnt});
      check_drain();
      get_result();
      if (i == 0) begin
        held = results();
        bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (results() != held || !out_valid || !busy || in_ready) bad++;
        end
        check("backpressure_hold", 64'(bad), 64'd0);
      end
      handshake(i == 1);
    end

    // Reset mid-window, with stage-by-stage latency
    start_window();
    send(12'h000, 12'h000, 13'd100);
    check("ed_latency_stage1", 64'(err_sum), 64'd0);
    send(12'h000, 12'h000, 13'd7);
    check("ed_latency_first_update", 64'(err_sum), 64'd100);
    @(negedge clk);
    check("partial_accum", 64'(results()), 64'({13'd107, 13'd100, 16'd2}));
    rst_n = 1'b0;
    #1;
    check("reset_mid_window", 64'({in_ready, out_valid, busy, results()}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_window();
    send(12'h001, 12'h002, 13'd0);
    send(12'h005, 12'h005, 13'd10);
    send(12'h000, 12'h000, 13'd0);
    send(12'h000, 12'h005, 13'd0);
    exp_q.push_back(model('{3, 0, 0, 5}));
    check_drain();
    get_result();
    handshake(1'b0);

    // Random gapped windows with stray start pulses during ACCUM
    for (int w = 0; w < 25; w++) begin
      eds.delete();
      start_window();
      for (int j = 0; j < WINDOW; j++) begin
        repeat ($urandom_range(0, 3)) begin
          start = ($urandom_range(0, 3) == 0);
          @(negedge clk);
          start = 1'b0;
        end
        x = 12'($urandom);
        y = 12'($urandom);
        case ($urandom_range(0, 3))
          0:       apx = {1'b0, x} + {1'b0, y};
          3:       apx = 13'($urandom);
          default: apx = approx_heaa(x, y);
        endcase
        eds.push_back(ed_of(x, y, apx));
        send(x, y, apx);
      end
      exp_q.push_back(model(eds));
      check_drain();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      get_result();
      handshake(w % 5 == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
